shiftreg_seq_ctrl: RTL

//   Sequencer for the 8-bit serial-in/parallel-out shift register (ports out, dir, in, clk, rst),

---
 rtl/shiftreg_seq_ctrl_pkg.sv | 18 +
 rtl/shiftreg_bit_counter.sv | 42 ++++
 rtl/shiftreg_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shiftreg_seq_ctrl_pkg.sv
// Shared types for the shift-register sequencer: FSM state encoding and
// serial direction codes. Optional checker macro: SHIFTREG_SEQ_CTRL_CHECK_EN.
package shiftreg_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // dir = 0: data moves toward MSB, serial input enters bit 0
  localparam logic DIR_MSB = 1'b0;
  // dir = 1: data moves toward LSB, serial input enters bit WIDTH-1
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/shiftreg_bit_counter.sv
// Bit counter for the serialiser: synchronous clear, count enable and a
// terminal flag at WIDTH-1. The count stops at the terminal value.
module shiftreg_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: clear wins, otherwise step while enabled and not yet terminal
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en && !last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer for an 8-bit SIPO shift register that shifts every clock.
// Accepts a word, clears the register, serialises the word into it in the
// requested direction, then captures the parallel output and reports it.
// Optional feature macro: SHIFTREG_SEQ_CTRL_CHECK_EN adds sticky chk_err.
module shiftreg_seq_ctrl
  import shiftreg_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  output logic             sr_rst,
  output logic             sr_dir,
  output logic             sr_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             dir_q, dir_d;
  logic             sr_in_q, sr_in_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
  logic             chk_err_q, chk_err_d;
`endif

  logic [CNT_W-1:0] cnt_s;
  logic             cnt_last_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;

  // Serial bit for position idx of the word in the chosen direction
  function automatic logic sel_bit(input logic [WIDTH-1:0] word,
                                   input logic [CNT_W-1:0] idx,
                                   input logic             dir);
    logic b;
    case (dir)
      DIR_MSB: b = word[CNT_W'(WIDTH - 1) - idx];
      DIR_LSB: b = word[idx];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign cnt_clr_s = (state_q == S_CLEAR);
  assign cnt_en_s  = (state_q == S_SHIFT);

  shiftreg_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s),
    .last(cnt_last_s)
  );

  // Next-state and next-output decode; serial bit is prepared one cycle ahead
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    dir_d      = dir_q;
    sr_in_d    = 1'b0;
    res_data_d = res_data_q;
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          buf_d   = req_data;
          dir_d   = req_dir;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
        sr_in_d = sel_bit(buf_q, {CNT_W{1'b0}}, dir_q);
      end
      S_SHIFT: begin
        if (cnt_last_s) begin
          state_d = S_CAPTURE;
          sr_in_d = 1'b0;
        end else begin
          state_d = S_SHIFT;
          sr_in_d = sel_bit(buf_q, cnt_s + CNT_W'(1), dir_q);
        end
      end
      S_CAPTURE: begin
        res_data_d = sr_q;
        state_d    = S_DONE;
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
        if (sr_q != buf_q) begin
          chk_err_d = 1'b1;
        end else begin
          chk_err_d = chk_err_q;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_q == S_DONE);
  end

  // FSM and all registered outputs; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= {WIDTH{1'b0}};
      dir_q       <= 1'b0;
      sr_in_q     <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {WIDTH{1'b0}};
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      dir_q       <= dir_d;
      sr_in_q     <= sr_in_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign sr_in     = sr_in_q;
  assign sr_dir    = dir_q;
  assign sr_rst    = rst | (state_q == S_CLEAR);
`ifdef SHIFTREG_SEQ_CTRL_CHECK_EN
  assign chk_err   = chk_err_q;
`endif

endmodule
